// File: rtl/demorgan_pkg.sv
// Shared types and sizing helpers for the De Morgan second-law sweep.
// The sweep walks all 2**(2*WIDTH) operand pairs; the error counter must hold 0..N.
package demorgan_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int num_vec(input int width);
    return 1 << (2 * width);
  endfunction

  function automatic int cnt_width(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/demorgan2nd_pair.sv
// Combinational pair of the two forms of De Morgan's second law for one operand pair.
module demorgan2nd_pair #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nor_f,
  output logic [WIDTH-1:0] and_f
);

  assign nor_f = ~(a | b);
  assign and_f = ~a & ~b;

endmodule

// File: rtl/demorgan2nd_sweep.sv
// Exhaustive sweep of ~(a|b) == ~a & ~b: FSM, vector counter, two-stage
// compare pipeline, and mismatch counter driving pass/done LEDs.
module demorgan2nd_sweep
  import demorgan_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fault_inj,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_cnt,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] nor_out,
  output logic [WIDTH-1:0] and_out
);

  localparam int              N         = num_vec(WIDTH);
  localparam int              IW        = 2 * WIDTH;
  localparam logic [IW-1:0]   IDX_LAST  = '1;
  localparam logic [CW-1:0]   ERR_MAX   = CW'(N);
  localparam logic [WIDTH-1:0] FAULT_BIT = WIDTH'(1);

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic             v1, v2;
  logic             issue;
  logic [WIDTH-1:0] nor_f, and_f;

  assign issue = (state == RUN);
  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == DONE);

  demorgan2nd_pair #(.WIDTH(WIDTH)) u_pair (
    .a     (idx[IW-1:WIDTH]),
    .b     (idx[WIDTH-1:0]),
    .nor_f (nor_f),
    .and_f (and_f)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (idx == IDX_LAST) state_nxt = DRAIN;
      // v2 && !v1: the last issued vector has just been counted.
      DRAIN: if (v2 && !v1) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      a_out   <= '0;
      b_out   <= '0;
      nor_out <= '0;
      and_out <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      v1 <= issue;
      v2 <= v1;

      if (state == IDLE && start) begin
        idx     <= '0;
        err_cnt <= '0;
        pass    <= 1'b0;
      end

      // Stage 1 loads only on issue so the display holds the last vector.
      if (issue) begin
        idx     <= idx + 1'b1;
        a_out   <= idx[IW-1:WIDTH];
        b_out   <= idx[WIDTH-1:0];
        nor_out <= nor_f;
        and_out <= and_f ^ (fault_inj ? FAULT_BIT : '0);
      end

      if (v1 && (nor_out != and_out) && (err_cnt != ERR_MAX))
        err_cnt <= err_cnt + 1'b1;

      if (state == DRAIN && state_nxt == DONE)
        pass <= (err_cnt == '0);
    end
  end

endmodule

// File: tb/tb_demorgan2nd_sweep.sv
// Self-checking bench for demorgan2nd_sweep: table-driven sweeps, random
// fault patterns against a behavioural model, reset abort and back-to-back runs.
module tb_demorgan2nd_sweep;

  localparam int W    = 4;
  localparam int NV   = 256;
  localparam int CW   = 9;
  localparam int W2   = 2;
  localparam int CW2  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic fault_inj = 1'b0;
  logic start2 = 1'b0;

  logic           busy, done, pass;
  logic [CW-1:0]  err_cnt;
  logic [W-1:0]   a_out, b_out, nor_out, and_out;

  logic           busy2, done2, pass2;
  logic [CW2-1:0] err_cnt2;
  logic [W2-1:0]  a_out2, b_out2, nor_out2, and_out2;

  always #5 clk = ~clk;

  demorgan2nd_sweep #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .fault_inj(fault_inj),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .a_out(a_out), .b_out(b_out), .nor_out(nor_out), .and_out(and_out)
  );

  demorgan2nd_sweep #(.WIDTH(W2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .fault_inj(1'b0),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .a_out(a_out2), .b_out(b_out2), .nor_out(nor_out2), .and_out(and_out2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    string name;
    int    mode;        // 0 no fault, 1 fault whole sweep, 2 fault on issues 60..69
    int    restart_at;  // RUN cycle to re-pulse start, -1 for none
    bit    pulse_done;  // also pulse start during DONE
    int    exp_err;
    bit    exp_pass;
  } sweep_vec_t;

  logic fi_pat [NV];

  int s_edges, s_busy, s_done, s_err, s_pass, m_err;

  // Reference: the law always holds, so a vector mismatches exactly when its
  // AND-form bit0 was flipped while fault_inj was high during its issue.
  task automatic run_sweep(input int restart_at, input bit pulse_done);
    int a, b, nor_v, and_v;
    bit seen;
    m_err = 0; s_edges = 0; s_busy = 0; s_done = 0; s_err = -1; s_pass = -1;
    seen = 0;
    start = 1'b1;
    fault_inj = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    s_edges = 1;
    for (int j = 0; j < 2 * NV; j++) begin
      if (busy) s_busy++;
      if (done) begin
        seen = 1;
        s_done++;
        s_err  = int'(err_cnt);
        s_pass = int'(pass);
        break;
      end
      fault_inj = (j < NV) ? fi_pat[j] : 1'b0;
      start = (j == restart_at);
      @(posedge clk); #1;
      s_edges++;
      if (j < NV) begin
        a = j / 16;
        b = j % 16;
        nor_v = (15 - (a | b));
        and_v = ((15 - a) & (15 - b)) ^ (fi_pat[j] ? 1 : 0);
        if (nor_v != and_v) m_err++;
        if (j % 17 == 0) begin
          check("stage1_a", a_out, a);
          check("stage1_b", b_out, b);
          check("stage1_nor", nor_out, nor_v);
          check("stage1_and", and_out, and_v);
        end
      end
    end
    fault_inj = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    start = pulse_done;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_single_pulse", done, 0);
    @(posedge clk); #1;
    check("no_relaunch", busy, 0);
    check("pass_held", pass, (s_pass == 1) ? 1 : 0);
  endtask

  sweep_vec_t tab [4];
  int done_t [3];
  int nd;

  initial begin
    tab[0] = '{"clean",      0, -1, 0, 0,   1};
    tab[1] = '{"all_fault",  1, -1, 0, 256, 0};
    tab[2] = '{"ten_fault",  2, -1, 0, 10,  0};
    tab[3] = '{"restart",    0, 50, 1, 0,   1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs_zero", {busy, done, pass, err_cnt, a_out, b_out, nor_out, and_out}, 0);
    check("rst_outputs_zero_w2", {busy2, done2, pass2, err_cnt2, a_out2, b_out2, nor_out2, and_out2}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", busy, 0);

    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < NV; j++)
        fi_pat[j] = (tab[t].mode == 1) || (tab[t].mode == 2 && j >= 60 && j < 70);
      run_sweep(tab[t].restart_at, tab[t].pulse_done);
      check({tab[t].name, "_edges"}, s_edges, 259);
      check({tab[t].name, "_busy"}, s_busy, 258);
      check({tab[t].name, "_done_cnt"}, s_done, 1);
      check({tab[t].name, "_err"}, s_err, tab[t].exp_err);
      check({tab[t].name, "_pass"}, s_pass, tab[t].exp_pass);
    end
    check("display_a_last", a_out, 15);
    check("display_b_last", b_out, 15);
    check("display_nor_last", nor_out, 0);

    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < NV; j++) fi_pat[j] = ($urandom_range(0, 7) == 0);
      run_sweep(-1, 0);
      check("rand_err", s_err, m_err);
      check("rand_pass", s_pass, (m_err == 0) ? 1 : 0);
      check("rand_edges", s_edges, 259);
    end

    // Reset mid-sweep aborts with no done pulse; next run is unaffected.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("busy_before_abort", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs_zero", {busy, done, pass, err_cnt, a_out, b_out, nor_out, and_out}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {busy, done}, 0);
    for (int j = 0; j < NV; j++) fi_pat[j] = 1'b0;
    run_sweep(-1, 0);
    check("after_abort_edges", s_edges, 259);
    check("after_abort_err", s_err, 0);
    check("after_abort_pass", s_pass, 1);

    // WIDTH=2 instance with start held: done every 16+4 cycles.
    start2 = 1'b1;
    nd = 0;
    for (int c = 0; c < 200 && nd < 3; c++) begin
      @(posedge clk); #1;
      if (done2) begin
        done_t[nd] = c;
        check("w2_pass", pass2, 1);
        nd++;
      end
    end
    start2 = 1'b0;
    check("w2_done_count", nd, 3);
    if (nd == 3) begin
      check("w2_period_1", done_t[1] - done_t[0], 20);
      check("w2_period_2", done_t[2] - done_t[1], 20);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
